// File: rtl/conveyor_chain_p.sv
// conveyor_chain_p: DEPTH-slot shift chain of in-flight commands.
// Slot 0 is the youngest and slot DEPTH-1 the oldest. Each slot carries a
// 3-bit stage stamp in bits [2:0]: bit2 exec, bit1 mem, bit0 wb (1 = done).
// The block derives per-slot stage-ready flags from register hazards
// against older valid slots. It also stalls itself while the oldest slot
// is unfinished.
// Optional build macro CONVEYOR_ZERO_REG_EN: when defined, register
// address 0 never produces a hazard match.
module conveyor_chain_p #(
  parameter int DEPTH       = 8,
  parameter int CMD_W       = 88,
  parameter int AW          = 5,
  parameter int SRC1_LSB    = 77,
  parameter int SRC2_LSB    = 72,
  parameter int DST_LSB     = 67,
  parameter int TAKE_LSB    = 30,
  parameter int JUMP_SHADOW = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [CMD_W-1:0]             cmd_in,
  input  logic                         cmd_valid,
  input  logic                         conveyor_stop,
  input  logic                         jump_start,
  input  logic [DEPTH*3-1:0]           stamp_flat,
  input  logic [DEPTH-1:0]             stamp_in,
  input  logic [DEPTH*AW-1:0]          take_flat,
  input  logic [DEPTH-1:0]             take_in,
  output logic [DEPTH*3-1:0]           reg_start_flat,
  output logic [DEPTH*CMD_W-1:0]       reg_out_flat,
  output logic                         conveyor_stop_out,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [15:0]                  retire_cnt
);

  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [2:0] STAMP_DONE = 3'b111;
  // A jump voids its own slot plus JUMP_SHADOW-1 further loads.
  localparam logic [3:0] SH_LOAD = (JUMP_SHADOW > 0) ? 4'(JUMP_SHADOW - 1) : 4'd0;

  logic [CMD_W-1:0] r_slot [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [3:0]       r_shadow;
  logic [15:0]      r_retire;

  logic             w_adv;
  logic             w_void;
  logic [CMD_W-1:0] w_slot_nxt [DEPTH];
  logic [DEPTH-1:0] w_vld_nxt;
  logic [AW-1:0]    w_src1 [DEPTH];
  logic [AW-1:0]    w_src2 [DEPTH];
  logic [AW-1:0]    w_dst  [DEPTH];
  logic [DEPTH-1:0] w_exec_ok;
  logic [DEPTH-1:0] w_mem_ok;
  logic [DEPTH-1:0] w_wb_ok;

  // Register address comparison; address 0 can be excluded from hazards.
  function automatic logic addr_eq(input logic [AW-1:0] a, input logic [AW-1:0] b);
`ifdef CONVEYOR_ZERO_REG_EN
    return (a == b) && (a != '0);
`else
    return a == b;
`endif
  endfunction

  genvar g;
  generate
    for (g = 0; g < DEPTH; g++) begin : g_slot
      assign w_src1[g] = r_slot[g][SRC1_LSB +: AW];
      assign w_src2[g] = r_slot[g][SRC2_LSB +: AW];
      assign w_dst[g]  = r_slot[g][DST_LSB +: AW];
      assign reg_out_flat[CMD_W*g +: CMD_W] = r_slot[g];
    end
  endgenerate

  assign conveyor_stop_out = (r_slot[DEPTH-1][2:0] != STAMP_DONE);
  assign w_adv             = !conveyor_stop && !conveyor_stop_out;
  assign w_void            = !cmd_valid || jump_start || (r_shadow != 4'd0);
  assign retire_cnt        = r_retire;

  // Next slot contents: shift on advance, then overlay stamp/take writes
  // that follow their command to its new position.
  always_comb begin
    w_vld_nxt = r_vld;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot_nxt[i] = r_slot[i];
    end
    if (w_adv) begin
      for (int i = DEPTH-1; i > 0; i--) begin
        w_slot_nxt[i] = r_slot[i-1];
        w_vld_nxt[i]  = r_vld[i-1];
      end
      w_slot_nxt[0] = cmd_in;
      w_vld_nxt[0]  = !w_void;
      if (w_void) begin
        w_slot_nxt[0][2:0] = STAMP_DONE;
      end
      for (int i = 0; i < DEPTH-1; i++) begin
        if (stamp_in[i]) begin
          w_slot_nxt[i+1][2:0] = stamp_flat[3*i +: 3];
        end
        if (take_in[i]) begin
          w_slot_nxt[i+1][TAKE_LSB +: AW] = take_flat[AW*i +: AW];
        end
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (stamp_in[i]) begin
          w_slot_nxt[i][2:0] = stamp_flat[3*i +: 3];
        end
        if (take_in[i]) begin
          w_slot_nxt[i][TAKE_LSB +: AW] = take_flat[AW*i +: AW];
        end
      end
    end
  end

  // Chain state, jump shadow counter and retire counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= CMD_W'(STAMP_DONE);
      end
      r_vld    <= '0;
      r_shadow <= '0;
      r_retire <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        r_slot[i] <= w_slot_nxt[i];
      end
      r_vld <= w_vld_nxt;
      if (w_adv) begin
        if (jump_start) begin
          r_shadow <= SH_LOAD;
        end else if (r_shadow != 4'd0) begin
          r_shadow <= r_shadow - 4'd1;
        end
        if (r_vld[DEPTH-1]) begin
          r_retire <= r_retire + 16'd1;
        end
      end
    end
  end

  // Hazard scan: each slot against every older valid slot.
  always_comb begin
    w_exec_ok = '1;
    w_mem_ok  = '1;
    w_wb_ok   = '1;
    for (int k = 0; k < DEPTH; k++) begin
      for (int j = k + 1; j < DEPTH; j++) begin
        if (r_vld[j]) begin
          if (!r_slot[j][0] &&
              (addr_eq(w_src1[k], w_dst[j]) || addr_eq(w_src2[k], w_dst[j]))) begin
            w_exec_ok[k] = 1'b0;
          end
          if (r_slot[j][2:0] != STAMP_DONE) begin
            if (addr_eq(w_src1[k], w_dst[j]) || addr_eq(w_src2[k], w_dst[j]) ||
                addr_eq(w_src1[j], w_dst[k]) || addr_eq(w_src2[j], w_dst[k])) begin
              w_mem_ok[k] = 1'b0;
            end
            if (addr_eq(w_dst[k], w_dst[j]) ||
                addr_eq(w_src1[j], w_dst[k]) || addr_eq(w_src2[j], w_dst[k])) begin
              w_wb_ok[k] = 1'b0;
            end
          end
        end
      end
    end
  end

  // Flag only the earliest pending stage of each live slot.
  always_comb begin
    reg_start_flat = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[k] && (r_slot[k][2:0] != STAMP_DONE)) begin
        if (!r_slot[k][2]) begin
          reg_start_flat[3*k+2] = w_exec_ok[k];
        end else if (!r_slot[k][1]) begin
          reg_start_flat[3*k+1] = w_mem_ok[k];
        end else begin
          reg_start_flat[3*k] = w_wb_ok[k];
        end
      end
    end
  end

  // Count live slots that still have work outstanding.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_vld[k] && (r_slot[k][2:0] != STAMP_DONE)) begin
        occupancy = occupancy + OCC_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_conveyor_chain_p.sv
// Testbench for conveyor_chain_p: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural chain model.
module tb_conveyor_chain_p;

  localparam int DEPTH    = 8;
  localparam int CMD_W    = 88;
  localparam int AW       = 5;
  localparam int SRC1_LSB = 77;
  localparam int SRC2_LSB = 72;
  localparam int DST_LSB  = 67;
  localparam int TAKE_LSB = 30;
  localparam int JS       = 2;
  localparam int OCC_W    = $clog2(DEPTH+1);
  localparam int WIDE     = DEPTH*CMD_W;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic [CMD_W-1:0]       cmd_in;
  logic                   cmd_valid;
  logic                   conveyor_stop;
  logic                   jump_start;
  logic [DEPTH*3-1:0]     stamp_flat;
  logic [DEPTH-1:0]       stamp_in;
  logic [DEPTH*AW-1:0]    take_flat;
  logic [DEPTH-1:0]       take_in;
  logic [DEPTH*3-1:0]     reg_start_flat;
  logic [WIDE-1:0]        reg_out_flat;
  logic                   conveyor_stop_out;
  logic [OCC_W-1:0]       occupancy;
  logic [15:0]            retire_cnt;

  conveyor_chain_p #(
    .DEPTH(DEPTH), .CMD_W(CMD_W), .AW(AW), .SRC1_LSB(SRC1_LSB), .SRC2_LSB(SRC2_LSB),
    .DST_LSB(DST_LSB), .TAKE_LSB(TAKE_LSB), .JUMP_SHADOW(JS)
  ) dut (
    .clk(clk), .reset(reset), .cmd_in(cmd_in), .cmd_valid(cmd_valid),
    .conveyor_stop(conveyor_stop), .jump_start(jump_start),
    .stamp_flat(stamp_flat), .stamp_in(stamp_in), .take_flat(take_flat), .take_in(take_in),
    .reg_start_flat(reg_start_flat), .reg_out_flat(reg_out_flat),
    .conveyor_stop_out(conveyor_stop_out), .occupancy(occupancy), .retire_cnt(retire_cnt)
  );

  // Behavioural model: the chain as an array of commands with valid flags.
  logic [CMD_W-1:0] m_slot [DEPTH];
  bit               m_vld  [DEPTH];
  int               m_shadow;
  logic [15:0]      m_retire;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [WIDE-1:0] act, input logic [WIDE-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [CMD_W-1:0] mk(input int s1, input int s2, input int d, input logic [2:0] st);
    logic [CMD_W-1:0] c;
    c = '0;
    c[SRC1_LSB +: AW] = AW'(s1);
    c[SRC2_LSB +: AW] = AW'(s2);
    c[DST_LSB +: AW]  = AW'(d);
    c[2:0] = st;
    return c;
  endfunction

  function automatic bit same_reg(input int a, input int b);
`ifdef CONVEYOR_ZERO_REG_EN
    return (a == b) && (a != 0);
`else
    return a == b;
`endif
  endfunction

  // Expected ready flags: find the slot's pending stage, then look for any
  // blocking older command according to that stage's rule.
  function automatic logic [2:0] m_start(input int k);
    logic [2:0] st, sj;
    int stage, s1k, s2k, dk, s1j, s2j, dj;
    st = m_slot[k][2:0];
    if (!m_vld[k] || st == 3'b111) return 3'b000;
    stage = !st[2] ? 2 : (!st[1] ? 1 : 0);
    s1k = int'(m_slot[k][SRC1_LSB +: AW]);
    s2k = int'(m_slot[k][SRC2_LSB +: AW]);
    dk  = int'(m_slot[k][DST_LSB +: AW]);
    for (int j = k + 1; j < DEPTH; j++) begin
      if (m_vld[j]) begin
        sj  = m_slot[j][2:0];
        s1j = int'(m_slot[j][SRC1_LSB +: AW]);
        s2j = int'(m_slot[j][SRC2_LSB +: AW]);
        dj  = int'(m_slot[j][DST_LSB +: AW]);
        case (stage)
          2: if (!sj[0] && (same_reg(s1k, dj) || same_reg(s2k, dj))) return 3'b000;
          1: if (sj != 3'b111 && (same_reg(s1k, dj) || same_reg(s2k, dj) ||
                                  same_reg(s1j, dk) || same_reg(s2j, dk))) return 3'b000;
          default: if (sj != 3'b111 && (same_reg(dk, dj) || same_reg(s1j, dk) ||
                                        same_reg(s2j, dk))) return 3'b000;
        endcase
      end
    end
    return 3'(1 << stage);
  endfunction

  task automatic model_step();
    logic [CMD_W-1:0] ns [DEPTH];
    bit nv [DEPTH];
    bit adv, bubble;
    int t;
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        m_slot[k] = CMD_W'(3'b111);
        m_vld[k]  = 1'b0;
      end
      m_shadow = 0;
      m_retire = '0;
      return;
    end
    adv = !conveyor_stop && (m_slot[DEPTH-1][2:0] == 3'b111);
    ns = m_slot;
    nv = m_vld;
    if (adv) begin
      if (m_vld[DEPTH-1]) m_retire = m_retire + 16'd1;
      for (int i = DEPTH-1; i > 0; i--) begin
        ns[i] = m_slot[i-1];
        nv[i] = m_vld[i-1];
      end
      bubble = !cmd_valid || jump_start || (m_shadow > 0);
      ns[0] = cmd_in;
      nv[0] = !bubble;
      if (bubble) ns[0][2:0] = 3'b111;
      if (jump_start) m_shadow = (JS > 0) ? JS - 1 : 0;
      else if (m_shadow > 0) m_shadow--;
    end
    for (int i = 0; i < DEPTH; i++) begin
      t = adv ? i + 1 : i;
      if (t < DEPTH) begin
        if (stamp_in[i]) ns[t][2:0] = stamp_flat[3*i +: 3];
        if (take_in[i])  ns[t][TAKE_LSB +: AW] = take_flat[AW*i +: AW];
      end
    end
    m_slot = ns;
    m_vld  = nv;
  endtask

  task automatic compare_all();
    logic [WIDE-1:0]    eo;
    logic [DEPTH*3-1:0] es;
    int occ;
    occ = 0;
    for (int k = 0; k < DEPTH; k++) begin
      eo[CMD_W*k +: CMD_W] = m_slot[k];
      es[3*k +: 3] = m_start(k);
      if (m_vld[k] && m_slot[k][2:0] != 3'b111) occ++;
    end
    check("reg_out", reg_out_flat, eo);
    check("reg_start", WIDE'(reg_start_flat), WIDE'(es));
    check("stop_out", WIDE'(conveyor_stop_out), WIDE'(m_slot[DEPTH-1][2:0] != 3'b111));
    check("occupancy", WIDE'(occupancy), WIDE'(occ));
    check("retire_cnt", WIDE'(retire_cnt), WIDE'(m_retire));
  endtask

  task automatic idle();
    reset = 1'b0; cmd_in = '0; cmd_valid = 1'b0; conveyor_stop = 1'b0; jump_start = 1'b0;
    stamp_flat = '0; stamp_in = '0; take_flat = '0; take_in = '0;
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  logic [CMD_W-1:0] ca, cb, cc;
  logic [WIDE-1:0]  all_done;
  logic [2:0]       exp_zr;
  logic [95:0]      rnd;

  initial begin
    idle();
    reset = 1'b1;
    @(negedge clk);
    do_reset();

    // Reset then eight bubble cycles: chain stays empty and finished.
    for (int i = 0; i < 8; i++) cycle();
    for (int k = 0; k < DEPTH; k++) all_done[CMD_W*k +: CMD_W] = CMD_W'(3'b111);
    check("empty_slots", reg_out_flat, all_done);
    check("empty_occ", WIDE'(occupancy), WIDE'(0));
    check("empty_stop", WIDE'(conveyor_stop_out), WIDE'(0));
    check("empty_retire", WIDE'(retire_cnt), WIDE'(0));

    // Exec hazard on slot 0 against pending wb in slot 1, cleared by a stamp write.
    do_reset();
    cmd_valid = 1'b1;
    cmd_in = mk(6, 7, 3, 3'b110); cycle();
    cmd_in = mk(3, 4, 5, 3'b000); cycle();
    idle();
    check("haz_slot0_blocked", WIDE'(reg_start_flat[2:0]), WIDE'(3'b000));
    check("haz_slot1_wb", WIDE'(reg_start_flat[5:3]), WIDE'(3'b001));
    conveyor_stop = 1'b1;
    stamp_in = 8'b0000_0010;
    stamp_flat[5:3] = 3'b111;
    cycle();
    idle();
    check("haz_slot0_ready", WIDE'(reg_start_flat[2:0]), WIDE'(3'b100));

    // Jump shadow of two: two voided loads, third loads normally.
    do_reset();
    cmd_valid = 1'b1; jump_start = 1'b1; cmd_in = mk(1, 2, 3, 3'b010);
    cycle();
    jump_start = 1'b0;
    check("jmp_void1_stamp", WIDE'(reg_out_flat[2:0]), WIDE'(3'b111));
    check("jmp_void1_occ", WIDE'(occupancy), WIDE'(0));
    cycle();
    check("jmp_void2_stamp", WIDE'(reg_out_flat[2:0]), WIDE'(3'b111));
    check("jmp_void2_occ", WIDE'(occupancy), WIDE'(0));
    cycle();
    check("jmp_load3_stamp", WIDE'(reg_out_flat[2:0]), WIDE'(3'b010));
    check("jmp_load3_occ", WIDE'(occupancy), WIDE'(1));

    // Reset in the middle of a shadow clears it.
    do_reset();
    cmd_valid = 1'b1; jump_start = 1'b1; cmd_in = mk(1, 2, 3, 3'b010);
    cycle();
    jump_start = 1'b0; reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    check("rst_shadow_occ", WIDE'(occupancy), WIDE'(1));

    // Unfinished oldest slot stalls the chain until its stamp completes.
    do_reset();
    cmd_valid = 1'b1; cmd_in = mk(1, 2, 3, 3'b011);
    cycle();
    idle();
    for (int i = 0; i < DEPTH-1; i++) cycle();
    check("stall_stop_out", WIDE'(conveyor_stop_out), WIDE'(1));
    cycle();
    check("stall_hold_stamp", WIDE'(reg_out_flat[CMD_W*(DEPTH-1) +: 3]), WIDE'(3'b011));
    check("stall_hold_retire", WIDE'(retire_cnt), WIDE'(0));
    stamp_in[DEPTH-1] = 1'b1;
    stamp_flat[3*(DEPTH-1) +: 3] = 3'b111;
    cycle();
    idle();
    check("stall_released", WIDE'(conveyor_stop_out), WIDE'(0));
    cycle();
    check("stall_retire_one", WIDE'(retire_cnt), WIDE'(1));

    // External stop with a stamp write: write lands in place, nothing shifts.
    do_reset();
    ca = mk(1, 2, 3, 3'b000); cb = mk(4, 5, 6, 3'b000); cc = mk(7, 8, 9, 3'b000);
    cmd_valid = 1'b1;
    cmd_in = ca; cycle();
    cmd_in = cb; cycle();
    cmd_in = cc; cycle();
    cmd_in = mk(10, 11, 12, 3'b000);
    conveyor_stop = 1'b1;
    stamp_in = 8'b0000_0100;
    stamp_flat[8:6] = 3'b101;
    cycle();
    idle();
    check("stop_write_slot2", WIDE'(reg_out_flat[CMD_W*2 +: 3]), WIDE'(3'b101));
    check("stop_noshift_slot0", WIDE'(reg_out_flat[CMD_W-1:0]), WIDE'(cc));

    // Register 0 hazard, depending on the build macro.
    do_reset();
    cmd_valid = 1'b1;
    cmd_in = mk(1, 2, 0, 3'b110); cycle();
    cmd_in = mk(0, 6, 7, 3'b000); cycle();
    idle();
`ifdef CONVEYOR_ZERO_REG_EN
    exp_zr = 3'b100;
`else
    exp_zr = 3'b000;
`endif
    check("zero_reg_slot0", WIDE'(reg_start_flat[2:0]), WIDE'(exp_zr));

    // Randomized traffic with small address space to provoke hazards.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      reset         = ($urandom_range(0, 299) == 0);
      cmd_valid     = ($urandom_range(0, 3) != 0);
      conveyor_stop = ($urandom_range(0, 4) == 0);
      jump_start    = ($urandom_range(0, 15) == 0);
      rnd = {$urandom, $urandom, $urandom};
      cmd_in = rnd[CMD_W-1:0];
      cmd_in[SRC1_LSB +: AW] = AW'($urandom_range(0, 3));
      cmd_in[SRC2_LSB +: AW] = AW'($urandom_range(0, 3));
      cmd_in[DST_LSB +: AW]  = AW'($urandom_range(0, 3));
      for (int i = 0; i < DEPTH; i++) begin
        stamp_in[i] = ($urandom_range(0, 4) == 0);
        stamp_flat[3*i +: 3] = ($urandom_range(0, 1) == 1) ? 3'b111 : 3'($urandom);
        take_in[i] = ($urandom_range(0, 3) == 0);
        take_flat[AW*i +: AW] = AW'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
